// File: rtl/gray_step_decoder.sv
// Gray-code position receiver: decodes a GW-bit Gray bus, classifies each sample as
// hold/up/down/illegal, and keeps a PW-bit relative position. Define POS_SAT_EN to saturate pos.
module gray_step_decoder #(
   parameter int unsigned GW = 3,
   parameter int unsigned PW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [GW-1:0] gray_in,
   input  logic          sample_en,
   input  logic          err_clr,
   output logic [GW-1:0] bin_out,
   output logic          step,
   output logic          dir_up,
   output logic          err,
   output logic          locked,
   output logic [PW-1:0] pos
);

   typedef enum logic [1:0] {StUnlocked, StTrack, StFault} state_e;

   state_e        state_q, state_d;
   logic [GW-1:0] bin_q, bin_d;
   logic          step_q, step_d;
   logic          dir_q, dir_d;
   logic          err_q, err_d;
   logic [PW-1:0] pos_q, pos_d;

   logic [GW-1:0] bin_new;
   logic [GW-1:0] diff;
   logic [PW-1:0] pos_up;
   logic [PW-1:0] pos_dn;

   // Each binary bit is the XOR of all Gray bits at or above it.
   function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
      logic [GW-1:0] b;
      b = '0;
      for (int i = 0; i < GW; i++) begin
         b[i] = ^(g >> i);
      end
      return b;
   endfunction

   assign bin_new = gray2bin(gray_in);
   assign diff    = bin_new - bin_q;

`ifdef POS_SAT_EN
   assign pos_up = (pos_q == {PW{1'b1}}) ? pos_q : pos_q + PW'(1);
   assign pos_dn = (pos_q == '0) ? pos_q : pos_q - PW'(1);
`else
   assign pos_up = pos_q + PW'(1);
   assign pos_dn = pos_q - PW'(1);
`endif

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      step_d  = 1'b0;
      dir_d   = dir_q;
      err_d   = 1'b0;
      pos_d   = pos_q;

      // err_clr takes priority over any sample in the same cycle.
      if (err_clr) begin
         state_d = StUnlocked;
      end else begin
         unique case (state_q)
            StUnlocked: begin
               if (sample_en) begin
                  bin_d   = bin_new;
                  state_d = StTrack;
               end
            end
            StTrack: begin
               if (sample_en) begin
                  if (diff == '0) begin
                     bin_d = bin_q;
                  end else if (diff == GW'(1)) begin
                     step_d = 1'b1;
                     dir_d  = 1'b1;
                     pos_d  = pos_up;
                     bin_d  = bin_new;
                  end else if (diff == {GW{1'b1}}) begin
                     step_d = 1'b1;
                     dir_d  = 1'b0;
                     pos_d  = pos_dn;
                     bin_d  = bin_new;
                  end else begin
                     err_d   = 1'b1;
                     state_d = StFault;
                  end
               end
            end
            StFault: begin
               state_d = StFault;
            end
            default: begin
               state_d = StUnlocked;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StUnlocked;
         bin_q   <= '0;
         step_q  <= 1'b0;
         dir_q   <= 1'b0;
         err_q   <= 1'b0;
         pos_q   <= '0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         step_q  <= step_d;
         dir_q   <= dir_d;
         err_q   <= err_d;
         pos_q   <= pos_d;
      end
   end

   assign bin_out = bin_q;
   assign step    = step_q;
   assign dir_up  = dir_q;
   assign err     = err_q;
   assign locked  = (state_q == StTrack);
   assign pos     = pos_q;

endmodule
